// File: rtl/fanout_bcast_pkg.sv
// Shared types for the broadcast fanout tree: the stage bus carried driver -> repeaters -> leaves.
// Stage fields are sized to the maxima; unused upper bits are tied to zero and trimmed by synthesis.
package fanout_bcast_pkg;

    localparam int MAX_CHILD = 16;
    localparam int MAX_REP   = 4;
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 valid;
        logic [MAX_CHILD-1:0] mask;
        logic [MAX_WIDTH-1:0] data;
    } stage_t;

    // Flat index of load l in child c; multiply by WIDTH for the bit offset in out_q.
    function automatic int load_idx(input int c, input int l, input int lpc);
        return c * lpc + l;
    endfunction

endpackage

// File: rtl/fanout_bcast_tree_if.sv
// Handshake, broadcast word and status bundle of the broadcast fanout tree.
// master drives the word and hold; slave is the tree returning loads and status.
interface fanout_bcast_tree_if #(
    parameter int WIDTH           = 1,
    parameter int NUM_CHILD       = 2,
    parameter int LOADS_PER_CHILD = 35,
    parameter int CNT_W           = 8
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic [WIDTH-1:0]                          in_data;
    logic [NUM_CHILD-1:0]                      ch_en;
    logic                                      hold;
    logic [NUM_CHILD*LOADS_PER_CHILD*WIDTH-1:0] out_q;
    logic                                      done;
    logic [CNT_W-1:0]                          bcast_cnt;

    modport master (
        output in_valid, in_data, ch_en, hold,
        input  in_ready, out_q, done, bcast_cnt
    );

    modport slave (
        input  in_valid, in_data, ch_en, hold,
        output in_ready, out_q, done, bcast_cnt
    );
endinterface

// File: rtl/fanout_bcast_leaf.sv
// One child of the tree: LOADS_PER_CHILD separate load registers fed by the last stage bus.
// Latency: loads update on the edge the stage word arrives; hold freezes every load.
module fanout_bcast_leaf
    import fanout_bcast_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int LOADS_PER_CHILD = 35,
    parameter int CHILD_IDX       = 0
) (
    input  logic                             clk1,
    input  logic                             rst_n,
    input  logic                             hold,
    input  stage_t                           st,
    output logic [LOADS_PER_CHILD*WIDTH-1:0] q,
    output logic                             hit
);

    logic unused_st;

    assign hit       = st.valid & st.mask[CHILD_IDX] & ~hold;
    assign unused_st = ^{st.mask, st.data};

    // Each load is a distinct register so the resizer sees the full per-load fanout.
    for (genvar l = 0; l < LOADS_PER_CHILD; l++) begin : g_load
        logic [WIDTH-1:0] r;

        always_ff @(posedge clk1 or negedge rst_n) begin
            if (!rst_n) begin
                r <= '0;
            end else if (hit) begin
                r <= st.data[WIDTH-1:0];
            end
        end

        assign q[l*WIDTH +: WIDTH] = r;
    end

endmodule

// File: rtl/fanout_bcast_tree.sv
// Broadcast one word from a driver register through REP_STAGES repeaters to NUM_CHILD leaves.
// Latency 2+REP_STAGES from input cycle to out_q/done; in_ready = ~hold, hold freezes everything.
module fanout_bcast_tree
    import fanout_bcast_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int NUM_CHILD       = 2,
    parameter int LOADS_PER_CHILD = 35,
    parameter int REP_STAGES      = 0,
    parameter int CNT_W           = 8
) (
    input logic                clk1,
    input logic                rst_n,
    fanout_bcast_tree_if.slave bus
);

    localparam int REP_N = (REP_STAGES > MAX_REP) ? MAX_REP : REP_STAGES;
    localparam int LW    = LOADS_PER_CHILD * WIDTH;

    logic [1:0]              rst_sync;
    logic                    rst_core_n;
    stage_t                  drv;
    stage_t                  arr;
    logic [NUM_CHILD-1:0]    leaf_hit;
    logic [NUM_CHILD*LW-1:0] q_all;
    logic                    done_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    unused_leaf_hit;

    // Reset asserts asynchronously but releases on a clock edge for the whole tree.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync[1];

    always_ff @(posedge clk1 or negedge rst_core_n) begin
        if (!rst_core_n) begin
            drv <= '0;
        end else if (!bus.hold) begin
            drv.valid <= bus.in_valid;
            if (bus.in_valid) begin
                drv.mask <= MAX_CHILD'(bus.ch_en);
                drv.data <= MAX_WIDTH'(bus.in_data);
            end
        end
    end

    for (genvar s = 0; s < REP_N; s++) begin : g_rep
        stage_t d;
        stage_t q;

        if (s == 0) begin : g_head
            assign d = drv;
        end else begin : g_link
            assign d = g_rep[s-1].q;
        end

        always_ff @(posedge clk1 or negedge rst_core_n) begin
            if (!rst_core_n) begin
                q <= '0;
            end else if (!bus.hold) begin
                q <= d;
            end
        end
    end

    if (REP_N == 0) begin : g_direct
        assign arr = drv;
    end else begin : g_tail
        assign arr = g_rep[REP_N-1].q;
    end

    for (genvar c = 0; c < NUM_CHILD; c++) begin : g_leaf
        fanout_bcast_leaf #(
            .WIDTH           (WIDTH),
            .LOADS_PER_CHILD (LOADS_PER_CHILD),
            .CHILD_IDX       (c)
        ) u_leaf (
            .clk1  (clk1),
            .rst_n (rst_core_n),
            .hold  (bus.hold),
            .st    (arr),
            .q     (q_all[load_idx(c, 0, LOADS_PER_CHILD)*WIDTH +: LW]),
            .hit   (leaf_hit[c])
        );
    end

    // Hit flags exist for per-child timing visibility; completion is tracked on the word itself.
    assign unused_leaf_hit = |leaf_hit;

    // done fires for any arriving word, even with an all-zero mask.
    always_ff @(posedge clk1 or negedge rst_core_n) begin
        if (!rst_core_n) begin
            done_r <= 1'b0;
            cnt_r  <= '0;
        end else begin
            done_r <= arr.valid & ~bus.hold;
            if (arr.valid && !bus.hold) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = ~bus.hold;
    assign bus.out_q     = q_all;
    assign bus.done      = done_r;
    assign bus.bcast_cnt = cnt_r;

endmodule

// File: tb/tb_fanout_bcast_tree.sv
`timescale 1ns/1ps
module tb_fanout_bcast_tree;

    localparam int NC  = 2;
    localparam int LPC = 35;
    localparam int NB  = NC * LPC;
    localparam int NI  = 3;
    localparam int NW  = 1024;

    logic       clk1  = 1'b0;
    logic       rst_n = 1'b0;
    logic       v     = 1'b0;
    logic [0:0] d     = 1'b0;
    logic [1:0] m     = 2'b00;
    logic       h     = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk1 = ~clk1;

    fanout_bcast_tree_if #(.WIDTH(1), .NUM_CHILD(NC), .LOADS_PER_CHILD(LPC), .CNT_W(8)) if0 ();
    fanout_bcast_tree_if #(.WIDTH(1), .NUM_CHILD(NC), .LOADS_PER_CHILD(LPC), .CNT_W(2)) if2 ();
    fanout_bcast_tree_if #(.WIDTH(1), .NUM_CHILD(NC), .LOADS_PER_CHILD(LPC), .CNT_W(8)) if3 ();

    assign if0.in_valid = v;  assign if0.in_data = d;  assign if0.ch_en = m;  assign if0.hold = h;
    assign if2.in_valid = v;  assign if2.in_data = d;  assign if2.ch_en = m;  assign if2.hold = h;
    assign if3.in_valid = v;  assign if3.in_data = d;  assign if3.ch_en = m;  assign if3.hold = h;

    fanout_bcast_tree #(.WIDTH(1), .NUM_CHILD(NC), .LOADS_PER_CHILD(LPC), .REP_STAGES(0), .CNT_W(8))
        dut0 (.clk1(clk1), .rst_n(rst_n), .bus(if0));
    fanout_bcast_tree #(.WIDTH(1), .NUM_CHILD(NC), .LOADS_PER_CHILD(LPC), .REP_STAGES(2), .CNT_W(2))
        dut2 (.clk1(clk1), .rst_n(rst_n), .bus(if2));
    fanout_bcast_tree #(.WIDTH(1), .NUM_CHILD(NC), .LOADS_PER_CHILD(LPC), .REP_STAGES(3), .CNT_W(8))
        dut3 (.clk1(clk1), .rst_n(rst_n), .bus(if3));

    logic [NB-1:0] act_q    [NI];
    logic          act_done [NI];
    logic [7:0]    act_cnt  [NI];
    logic          act_rdy  [NI];

    always_comb begin
        act_q[0] = if0.out_q;  act_done[0] = if0.done;  act_cnt[0] = if0.bcast_cnt;          act_rdy[0] = if0.in_ready;
        act_q[1] = if2.out_q;  act_done[1] = if2.done;  act_cnt[1] = {6'b0, if2.bcast_cnt};  act_rdy[1] = if2.in_ready;
        act_q[2] = if3.out_q;  act_done[2] = if3.done;  act_cnt[2] = if3.bcast_cnt;          act_rdy[2] = if3.in_ready;
    end

    // Reference model: each accepted word needs 1+REP further non-hold edges to land.
    logic          wdat [NW];
    logic [1:0]    wmsk [NW];
    int            rem  [NI][NW];
    int            nw;
    int            first    [NI];
    int            reps     [NI];
    int            cmod     [NI];
    logic [NB-1:0] exp_q    [NI];
    logic          exp_done [NI];
    int            exp_cnt  [NI];

    task automatic model_clear();
        nw = 0;
        for (int k = 0; k < NI; k++) begin
            first[k] = 0; exp_q[k] = '0; exp_done[k] = 1'b0; exp_cnt[k] = 0;
        end
    endtask

    task automatic step(input logic iv, input logic id, input logic [1:0] im, input logic ih);
        @(negedge clk1);
        v = iv; d = id; m = im; h = ih;
        for (int k = 0; k < NI; k++) begin
            exp_done[k] = 1'b0;
            if (!ih) begin
                for (int j = first[k]; j < nw; j++) begin
                    rem[k][j] = rem[k][j] - 1;
                    if (rem[k][j] == 0) begin
                        exp_done[k] = 1'b1;
                        exp_cnt[k]  = (exp_cnt[k] + 1) % cmod[k];
                        for (int c = 0; c < NC; c++)
                            if (wmsk[j][c])
                                for (int l = 0; l < LPC; l++) exp_q[k][c*LPC+l] = wdat[j];
                        first[k] = j + 1;
                    end
                end
            end
        end
        if (iv && !ih) begin
            wdat[nw] = id; wmsk[nw] = im;
            for (int k = 0; k < NI; k++) rem[k][nw] = 1 + reps[k];
            nw++;
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk1);
        v = 1'b0; h = 1'b0; rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0; v = 1'b0; h = 1'b0;
        @(negedge clk1);
        release_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            rst_n = 1'b0; v = 1'($urandom); d = 1'($urandom); m = 2'($urandom); h = 1'b0;
            #1;
            for (int k = 0; k < NI; k++) begin
                n_chk += 4;
                if (act_q[k] !== '0)      begin n_fail++; $display("FAIL reset_q[%0d] got %h want 0", k, act_q[k]); end
                if (act_done[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d] got %b want 0", k, act_done[k]); end
                if (act_cnt[k] !== 8'd0)  begin n_fail++; $display("FAIL reset_cnt[%0d] got %0d want 0", k, act_cnt[k]); end
                if (act_rdy[k] !== 1'b1)  begin n_fail++; $display("FAIL reset_rdy[%0d] got %b want 1", k, act_rdy[k]); end
            end
        end
        release_reset();
    endtask

    task automatic test_single_word();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) step(1'b1, 1'b1, 2'b11, 1'b0);
            else        step(1'b0, 1'b0, 2'b00, 1'b0);
            if (i == 1) begin
                n_chk += 3;
                if (act_q[0] !== {NB{1'b1}}) begin n_fail++; $display("FAIL single_all_ones got %h", act_q[0]); end
                if (act_done[0] !== 1'b1)    begin n_fail++; $display("FAIL single_done got %b want 1", act_done[0]); end
                if (act_cnt[0] !== 8'd1)     begin n_fail++; $display("FAIL single_cnt got %0d want 1", act_cnt[0]); end
            end
            for (int k = 0; k < NI; k++) begin
                n_chk += 3;
                if (act_q[k] !== exp_q[k])       begin n_fail++; $display("FAIL single_q[%0d] cyc %0d got %h want %h", k, i, act_q[k], exp_q[k]); end
                if (act_done[k] !== exp_done[k]) begin n_fail++; $display("FAIL single_done[%0d] cyc %0d got %b want %b", k, i, act_done[k], exp_done[k]); end
                if (act_cnt[k] !== 8'(exp_cnt[k])) begin n_fail++; $display("FAIL single_cnt[%0d] cyc %0d got %0d want %0d", k, i, act_cnt[k], exp_cnt[k]); end
            end
        end
    endtask

    task automatic test_mask();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      step(1'b1, 1'b1, 2'b01, 1'b0);
            else if (i == 5) step(1'b1, 1'b0, 2'b00, 1'b0);
            else             step(1'b0, 1'b0, 2'b00, 1'b0);
            if (i == 1) begin
                n_chk++;
                if (act_q[0] !== {{LPC{1'b0}}, {LPC{1'b1}}}) begin n_fail++; $display("FAIL mask_child0_only got %h", act_q[0]); end
            end
            for (int k = 0; k < NI; k++) begin
                n_chk += 3;
                if (act_q[k] !== exp_q[k])       begin n_fail++; $display("FAIL mask_q[%0d] cyc %0d got %h want %h", k, i, act_q[k], exp_q[k]); end
                if (act_done[k] !== exp_done[k]) begin n_fail++; $display("FAIL mask_done[%0d] cyc %0d got %b want %b", k, i, act_done[k], exp_done[k]); end
                if (act_cnt[k] !== 8'(exp_cnt[k])) begin n_fail++; $display("FAIL mask_cnt[%0d] cyc %0d got %0d want %0d", k, i, act_cnt[k], exp_cnt[k]); end
            end
        end
    endtask

    task automatic test_hold_stream();
        int ndone;
        logic ih;
        ndone = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            ih = (i >= 2 && i <= 4);
            case (i)
                0:       step(1'b1, 1'b1, 2'b11, 1'b0);
                1:       step(1'b1, 1'b0, 2'b10, 1'b0);
                2, 3, 4: step(1'b1, 1'b1, 2'b11, 1'b1);
                5:       step(1'b1, 1'b1, 2'b01, 1'b0);
                default: step(1'b0, 1'b0, 2'b00, 1'b0);
            endcase
            if (act_done[1] === 1'b1) ndone++;
            for (int k = 0; k < NI; k++) begin
                n_chk += 4;
                if (act_rdy[k] !== !ih)          begin n_fail++; $display("FAIL hold_rdy[%0d] cyc %0d got %b want %b", k, i, act_rdy[k], !ih); end
                if (act_q[k] !== exp_q[k])       begin n_fail++; $display("FAIL hold_q[%0d] cyc %0d got %h want %h", k, i, act_q[k], exp_q[k]); end
                if (act_done[k] !== exp_done[k]) begin n_fail++; $display("FAIL hold_done[%0d] cyc %0d got %b want %b", k, i, act_done[k], exp_done[k]); end
                if (act_cnt[k] !== 8'(exp_cnt[k])) begin n_fail++; $display("FAIL hold_cnt[%0d] cyc %0d got %0d want %0d", k, i, act_cnt[k], exp_cnt[k]); end
            end
        end
        n_chk++;
        if (ndone != 3) begin n_fail++; $display("FAIL hold_done_count got %0d want 3", ndone); end
    endtask

    task automatic test_wrap();
        int seq [5];
        int idx;
        seq = '{1, 2, 3, 0, 1};
        idx = 0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i % 4 == 0 && i < 20) step(1'b1, 1'(i / 4), 2'b11, 1'b0);
            else                      step(1'b0, 1'b0, 2'b00, 1'b0);
            if (act_done[1] === 1'b1 && idx < 5) begin
                n_chk++;
                if (act_cnt[1] !== 8'(seq[idx])) begin n_fail++; $display("FAIL wrap_seq[%0d] got %0d want %0d", idx, act_cnt[1], seq[idx]); end
                idx++;
            end
            for (int k = 0; k < NI; k++) begin
                n_chk++;
                if (act_cnt[k] !== 8'(exp_cnt[k])) begin n_fail++; $display("FAIL wrap_cnt[%0d] cyc %0d got %0d want %0d", k, i, act_cnt[k], exp_cnt[k]); end
            end
        end
        n_chk++;
        if (idx != 5) begin n_fail++; $display("FAIL wrap_done_count got %0d want 5", idx); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 1'($urandom), 2'($urandom), ($urandom % 5) == 0);
            for (int k = 0; k < NI; k++) begin
                n_chk += 3;
                if (act_q[k] !== exp_q[k])       begin n_fail++; $display("FAIL rand_q[%0d] cyc %0d got %h want %h", k, i, act_q[k], exp_q[k]); end
                if (act_done[k] !== exp_done[k]) begin n_fail++; $display("FAIL rand_done[%0d] cyc %0d got %b want %b", k, i, act_done[k], exp_done[k]); end
                if (act_cnt[k] !== 8'(exp_cnt[k])) begin n_fail++; $display("FAIL rand_cnt[%0d] cyc %0d got %0d want %0d", k, i, act_cnt[k], exp_cnt[k]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        step(1'b1, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 2'b11, 1'b0);
        @(negedge clk1);
        rst_n = 1'b0; v = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            n_chk += 3;
            if (act_q[k] !== '0)      begin n_fail++; $display("FAIL midrst_q[%0d] got %h want 0", k, act_q[k]); end
            if (act_done[k] !== 1'b0) begin n_fail++; $display("FAIL midrst_done[%0d] got %b want 0", k, act_done[k]); end
            if (act_cnt[k] !== 8'd0)  begin n_fail++; $display("FAIL midrst_cnt[%0d] got %0d want 0", k, act_cnt[k]); end
        end
        @(negedge clk1);
        release_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 2'b00, 1'b0);
            for (int k = 0; k < NI; k++) begin
                n_chk += 2;
                if (act_q[k] !== exp_q[k])       begin n_fail++; $display("FAIL midrst_after_q[%0d] cyc %0d got %h want %h", k, i, act_q[k], exp_q[k]); end
                if (act_done[k] !== exp_done[k]) begin n_fail++; $display("FAIL midrst_after_done[%0d] cyc %0d got %b want %b", k, i, act_done[k], exp_done[k]); end
            end
        end
    endtask

    initial begin
        reps = '{0, 2, 3};
        cmod = '{256, 4, 256};
        model_clear();
        test_reset();
        test_single_word();
        test_mask();
        test_hold_stream();
        test_wrap();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
